// File: rtl/rob_complete_arbiter_if.sv
// Shared core types plus the bundle of completion requests from the execution
// units and the single completion port into the reorder buffer.
package params_pkg;
  localparam int ROB_ENTRIES = 32;
  localparam int DATA_W      = 64;
  localparam int VADDR_W     = 64;
  localparam int CAUSE_W     = 6;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [VADDR_W-1:0] vaddr_t;
  typedef logic [CAUSE_W-1:0] excpt_cause_t;
endpackage

interface rob_complete_arbiter_if #(
  parameter int NUM_REQ     = 3,
  parameter int ROB_ENTRIES = params_pkg::ROB_ENTRIES
);
  localparam int IDX_W = $clog2(ROB_ENTRIES);
  typedef logic [IDX_W-1:0] rob_idx_t;

  logic                                            flush_i;
  logic [NUM_REQ-1:0]                              req_valid_i;
  logic [NUM_REQ-1:0][IDX_W-1:0]                   req_idx_i;
  logic [NUM_REQ-1:0][params_pkg::DATA_W-1:0]      req_data_i;
  logic [NUM_REQ-1:0]                              req_excpt_i;
  logic [NUM_REQ-1:0][params_pkg::CAUSE_W-1:0]     req_cause_i;
  logic [NUM_REQ-1:0][params_pkg::VADDR_W-1:0]     req_tval_i;
  logic [NUM_REQ-1:0]                              req_ready_o;

  logic                                            complete_valid_o;
  logic                                            complete_excpt_o;
  rob_idx_t                                        complete_idx_o;
  params_pkg::data_t                               complete_data_o;
  params_pkg::excpt_cause_t                        complete_cause_o;
  params_pkg::vaddr_t                              complete_tval_o;
  logic [15:0]                                     conflict_cnt_o;

  modport slave (
    input  flush_i, req_valid_i, req_idx_i, req_data_i, req_excpt_i,
           req_cause_i, req_tval_i,
    output req_ready_o, complete_valid_o, complete_excpt_o, complete_idx_o,
           complete_data_o, complete_cause_o, complete_tval_o, conflict_cnt_o
  );

  modport master (
    output flush_i, req_valid_i, req_idx_i, req_data_i, req_excpt_i,
           req_cause_i, req_tval_i,
    input  req_ready_o, complete_valid_o, complete_excpt_o, complete_idx_o,
           complete_data_o, complete_cause_o, complete_tval_o, conflict_cnt_o
  );
endinterface

// File: rtl/rob_complete_arbiter.sv
// Round-robin arbiter funnelling ALU/MUL/MEM completions into the single ROB
// completion port, with one registered stage and a conflict-cycle counter.
module rob_complete_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ROB_ENTRIES = params_pkg::ROB_ENTRIES
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  rob_complete_arbiter_if.slave   bus
);
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = $clog2(ROB_ENTRIES);

  logic [RR_W-1:0]          rr_q;
  logic [RR_W-1:0]          gnt_idx;
  logic [RR_W-1:0]          cand;
  logic [NUM_REQ-1:0]       gnt;
  logic                     gnt_any;
  logic                     multi_req;
  logic [15:0]              conflict_cnt_q;

  logic                     vld_p1;
  logic                     excpt_p1;
  logic [IDX_W-1:0]         idx_p1;
  params_pkg::data_t        data_p1;
  params_pkg::excpt_cause_t cause_p1;
  params_pkg::vaddr_t       tval_p1;

  // Wraps at NUM_REQ-1 so non-power-of-two counts never visit unused codes.
  function automatic logic [RR_W-1:0] rr_inc(input logic [RR_W-1:0] v);
    if (v == RR_W'(NUM_REQ - 1)) return '0;
    return v + RR_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  // Stage p0: combinational round-robin grant, suppressed during flush and reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = rr_q;
    gnt_any = 1'b0;
    cand    = rr_q;
    if (!rst_i && !bus.flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && bus.req_valid_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
        cand = rr_inc(cand);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign multi_req = ($countones(bus.req_valid_i) > 1) && !bus.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q           <= '0;
      conflict_cnt_q <= '0;
      vld_p1         <= 1'b0;
      excpt_p1       <= 1'b0;
    end else begin
      if (gnt_any) rr_q <= rr_inc(gnt_idx);
      if (multi_req) conflict_cnt_q <= sat_inc16(conflict_cnt_q);
      vld_p1   <= gnt_any;
      excpt_p1 <= gnt_any && bus.req_excpt_i[gnt_idx];
    end
  end

  // Stage p1: granted payload, held across idle cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_p1   <= '0;
      data_p1  <= '0;
      cause_p1 <= '0;
      tval_p1  <= '0;
    end else if (gnt_any) begin
      idx_p1   <= bus.req_idx_i[gnt_idx];
      data_p1  <= bus.req_data_i[gnt_idx];
      cause_p1 <= bus.req_cause_i[gnt_idx];
      tval_p1  <= bus.req_tval_i[gnt_idx];
    end
  end

  assign bus.req_ready_o      = gnt;
  assign bus.complete_valid_o = vld_p1;
  assign bus.complete_excpt_o = excpt_p1;
  assign bus.complete_idx_o   = idx_p1;
  assign bus.complete_data_o  = data_p1;
  assign bus.complete_cause_o = cause_p1;
  assign bus.complete_tval_o  = tval_p1;
  assign bus.conflict_cnt_o   = conflict_cnt_q;
endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed bench for rob_complete_arbiter: reset, single grant, contention,
// exception, flush, counter saturation and asynchronous reset.
module tb_rob_complete_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;
  int   errors = 0;
  int   checks = 0;

  rob_complete_arbiter_if bus ();

  rob_complete_arbiter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] idx, input logic [63:0] data);
    bus.req_idx_i[i]   = idx;
    bus.req_data_i[i]  = data;
    bus.req_excpt_i[i] = 1'b0;
    bus.req_cause_i[i] = '0;
    bus.req_tval_i[i]  = '0;
  endtask

  initial begin
    logic [2:0] exp_g   [6];
    logic [4:0] exp_idx [6];
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_idx = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

    rst_i           = 1'b1;
    bus.flush_i     = 1'b0;
    bus.req_valid_i = '0;
    for (int i = 0; i < 3; i++) set_req(i, '0, '0);

    // Reset: ready stays low even with requests present.
    #2;
    bus.req_valid_i = 3'b111;
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'h0);
    chk("rst_valid", 64'(bus.complete_valid_o), 64'h0);
    cyc();
    bus.req_valid_i = '0;
    rst_i = 1'b0;
    cyc();
    cyc();
    chk("idle_valid", 64'(bus.complete_valid_o), 64'h0);
    chk("idle_excpt", 64'(bus.complete_excpt_o), 64'h0);
    chk("idle_data", bus.complete_data_o, 64'h0);
    chk("idle_cnt", 64'(bus.conflict_cnt_o), 64'h0);

    // Single MUL request.
    set_req(1, 5'd5, 64'h2A);
    bus.req_valid_i = 3'b010;
    #1;
    chk("mul_ready", 64'(bus.req_ready_o), 64'h2);
    cyc();
    bus.req_valid_i = '0;
    chk("mul_valid", 64'(bus.complete_valid_o), 64'h1);
    chk("mul_idx", 64'(bus.complete_idx_o), 64'h5);
    chk("mul_data", bus.complete_data_o, 64'h2A);
    chk("mul_excpt", 64'(bus.complete_excpt_o), 64'h0);
    cyc();
    chk("mul_pulse", 64'(bus.complete_valid_o), 64'h0);
    chk("mul_hold", bus.complete_data_o, 64'h2A);

    // Contention from a fresh reset.
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), 64'h100 + 64'(i));
    bus.req_valid_i = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_grant%0d", c), 64'(bus.req_ready_o), 64'(exp_g[c]));
      cyc();
      chk($sformatf("rr_idx%0d", c), 64'(bus.complete_idx_o), 64'(exp_idx[c]));
    end
    bus.req_valid_i = '0;
    chk("rr_cnt", 64'(bus.conflict_cnt_o), 64'd6);

    // Exception completion from MEM at the last ROB slot.
    set_req(2, 5'd31, 64'hDEAD);
    bus.req_excpt_i[2] = 1'b1;
    bus.req_cause_i[2] = 6'd13;
    bus.req_tval_i[2]  = 64'h8000_1000;
    bus.req_valid_i    = 3'b100;
    #1;
    chk("exc_ready", 64'(bus.req_ready_o), 64'h4);
    cyc();
    bus.req_valid_i = '0;
    chk("exc_valid", 64'(bus.complete_valid_o), 64'h1);
    chk("exc_excpt", 64'(bus.complete_excpt_o), 64'h1);
    chk("exc_cause", 64'(bus.complete_cause_o), 64'd13);
    chk("exc_tval", bus.complete_tval_o, 64'h8000_1000);
    chk("exc_idx", 64'(bus.complete_idx_o), 64'd31);
    cyc();
    chk("exc_idle_v", 64'(bus.complete_valid_o), 64'h0);
    chk("exc_idle_e", 64'(bus.complete_excpt_o), 64'h0);
    chk("exc_hold", bus.complete_tval_o, 64'h8000_1000);

    // Flush: ALU granted in N, flush in N+1, MUL wins in N+2.
    set_req(0, 5'd7, 64'h77);
    bus.req_valid_i = 3'b001;
    #1;
    chk("fl_n_ready", 64'(bus.req_ready_o), 64'h1);
    cyc();
    set_req(0, 5'd8, 64'h88);
    set_req(1, 5'd4, 64'h44);
    bus.req_valid_i = 3'b011;
    bus.flush_i     = 1'b1;
    #1;
    chk("fl_ready", 64'(bus.req_ready_o), 64'h0);
    chk("fl_prev_valid", 64'(bus.complete_valid_o), 64'h1);
    chk("fl_prev_idx", 64'(bus.complete_idx_o), 64'd7);
    cyc();
    bus.flush_i = 1'b0;
    chk("fl_next_valid", 64'(bus.complete_valid_o), 64'h0);
    chk("fl_cnt", 64'(bus.conflict_cnt_o), 64'd6);
    #1;
    chk("fl_after_ready", 64'(bus.req_ready_o), 64'h2);
    cyc();
    bus.req_valid_i = 3'b001;
    chk("fl_mul_idx", 64'(bus.complete_idx_o), 64'd4);
    #1;
    chk("fl_alu_ready", 64'(bus.req_ready_o), 64'h1);
    cyc();
    bus.req_valid_i = '0;
    chk("fl_alu_idx", 64'(bus.complete_idx_o), 64'd8);
    chk("fl_cnt2", 64'(bus.conflict_cnt_o), 64'd7);

    // Conflict counter saturation.
    bus.req_valid_i = 3'b011;
    for (int c = 0; c < 65540; c++) @(posedge clk_i);
    #1;
    bus.req_valid_i = '0;
    chk("sat_cnt", 64'(bus.conflict_cnt_o), 64'hFFFF);
    cyc();
    chk("sat_hold", 64'(bus.conflict_cnt_o), 64'hFFFF);

    // Asynchronous reset while a completion is registered.
    set_req(0, 5'd9, 64'h99);
    bus.req_valid_i = 3'b001;
    cyc();
    bus.req_valid_i = '0;
    chk("ar_pre_valid", 64'(bus.complete_valid_o), 64'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.complete_valid_o), 64'h0);
    chk("ar_idx", 64'(bus.complete_idx_o), 64'h0);
    chk("ar_cnt", 64'(bus.conflict_cnt_o), 64'h0);
    cyc();
    #1;
    rst_i = 1'b0;
    cyc();
    chk("ar_post_valid", 64'(bus.complete_valid_o), 64'h0);
    cyc();
    chk("ar_post_valid2", 64'(bus.complete_valid_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
